// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target bridging address/pointer/data bus transfers to a byte register port.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer after each written or ACKed read byte.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    logic [2:0] scl_q, sda_q;
    logic [3:0] state, bit_cnt;
    logic [7:0] sh, rx_byte;
    logic       rw, ack_on, sda_oe;
    logic       scl_rise, scl_fall, sda_in, start_det, stop_det;
    logic       in_ack, rx_state, rd_load;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], scl};
            sda_q <= {sda_q[1:0], sda};
        end
    end

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign sda_in    = sda_q[1];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign rx_byte   = {sh[6:0], sda_in};
    assign in_ack    = (state == S_ADDR_ACK) || (state == S_PTR_ACK) || (state == S_WDATA_ACK);
    assign rx_state  = (state == S_ADDR) || (state == S_PTR) || (state == S_WDATA);
    // The fetch happens on the fall ending an address ACK (rw=1) or starting a follow-on read byte
    assign rd_load   = !start_det && !stop_det && scl_fall &&
                       ((state == S_ADDR_ACK && ack_on && rw) || (state == S_RDATA && bit_cnt == 4'd0));
    assign reg_rd    = rd_load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            sh        <= '0;
            rw        <= 1'b0;
            ack_on    <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wr    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            if (AUTOINC && reg_wr)
                reg_addr <= reg_addr + 8'd1;
            if (start_det) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                ack_on  <= 1'b0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= S_IDLE;
                busy   <= 1'b0;
                ack_on <= 1'b0;
                sda_oe <= 1'b0;
            end else if (rd_load) begin
                sh      <= reg_rdata;
                sda_oe  <= ~reg_rdata[7];
                bit_cnt <= 4'd1;
                ack_on  <= 1'b0;
                state   <= S_RDATA;
            end else if (in_ack) begin
                if (scl_fall) begin
                    ack_on  <= ~ack_on;
                    sda_oe  <= ~ack_on;
                    bit_cnt <= '0;
                    if (ack_on)
                        state <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                end
            end else if (rx_state && scl_rise) begin
                sh      <= rx_byte;
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd7) begin
                    if (state == S_ADDR) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            busy  <= 1'b1;
                            rw    <= rx_byte[0];
                            state <= S_ADDR_ACK;
                        end else begin
                            state <= S_IGNORE;
                        end
                    end else if (state == S_PTR) begin
                        reg_addr <= rx_byte;
                        state    <= S_PTR_ACK;
                    end else begin
                        reg_wdata <= rx_byte;
                        reg_wr    <= 1'b1;
                        state     <= S_WDATA_ACK;
                    end
                end
            end else if (state == S_RDATA && scl_fall) begin
                if (bit_cnt == 4'd8) begin
                    sda_oe <= 1'b0;
                    state  <= S_RDATA_ACK;
                end else begin
                    sda_oe  <= ~sh[6];
                    sh      <= {sh[6:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (state == S_RDATA_ACK && scl_rise) begin
                if (!sda_in) begin
                    state   <= S_RDATA;
                    bit_cnt <= '0;
                    if (AUTOINC)
                        reg_addr <= reg_addr + 8'd1;
                end else begin
                    state <= S_IGNORE;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bit-banged I2C controller driving i2c_slave_regs with directed transactions.
// Expectations follow I2C_SLAVE_AUTOINC_EN when it is defined for the build.
module tb_i2c_slave_regs;
`ifdef I2C_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int Q = 100;

    logic clk = 1'b0, reset_n = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
    wire sda;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic reg_wr, reg_rd, busy;
    logic [7:0] mem [0:255];
    logic [7:0] wr_a [0:63];
    logic [7:0] wr_d [0:63];
    logic [7:0] rd_a [0:63];
    int wr_cnt = 0, rd_cnt = 0, low_cnt = 0, busy_cnt = 0;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;
    assign sda = m_sda ? 1'bz : 1'b0;
    pullup (sda);
    assign reg_rdata = mem[reg_addr];

    i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
        .clk(clk), .reset_n(reset_n), .scl(m_scl), .sda(sda),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
        .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy)
    );

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_a[wr_cnt % 64] <= reg_addr;
            wr_d[wr_cnt % 64] <= reg_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (reg_rd) begin
            rd_a[rd_cnt % 64] <= reg_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (m_sda && sda === 1'b0) low_cnt <= low_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic bus_start;
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; ack = sda; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic read_bits(input int n, output logic [7:0] d);
        m_sda = 1'b1;
        d = 8'h00;
        for (int i = 0; i < n; i++) begin
            #Q; m_scl = 1'b1; #Q; d = {d[6:0], sda}; #Q; m_scl = 1'b0; #Q;
        end
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        read_bits(8, d);
        send_bit(ack_bit);
    endtask

    task automatic test_reset;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda: got %b want 1", sda); end
        n_cmp++; if (reg_addr !== 8'h00) begin n_err++; $display("FAIL rst_addr: got %h want 00", reg_addr); end
        n_cmp++; if (reg_wdata !== 8'h00) begin n_err++; $display("FAIL rst_wdata: got %h want 00", reg_wdata); end
        n_cmp++; if (reg_wr !== 1'b0) begin n_err++; $display("FAIL rst_wr: got %b want 0", reg_wr); end
        n_cmp++; if (reg_rd !== 1'b0) begin n_err++; $display("FAIL rst_rd: got %b want 0", reg_rd); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_write;
        logic a0, a1, a2, a3;
        int base;
        base = wr_cnt;
        bus_start;
        write_byte(8'hA0, a0); write_byte(8'h03, a1); write_byte(8'hA5, a2); write_byte(8'h3C, a3);
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL wr_acks: got %b want 0000", {a0, a1, a2, a3}); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_on: got %b want 1", busy); end
        bus_stop;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_off: got %b want 0", busy); end
        n_cmp++; if (wr_cnt - base !== 2) begin n_err++; $display("FAIL wr_count: got %0d want 2", wr_cnt - base); end
        n_cmp++; if (wr_a[base] !== 8'h03 || wr_d[base] !== 8'hA5) begin n_err++; $display("FAIL wr_0: got %h/%h want 03/a5", wr_a[base], wr_d[base]); end
        n_cmp++; if (wr_a[base+1] !== (AUTOINC ? 8'h04 : 8'h03) || wr_d[base+1] !== 8'h3C) begin n_err++; $display("FAIL wr_1: got %h/%h want %h/3c", wr_a[base+1], wr_d[base+1], AUTOINC ? 8'h04 : 8'h03); end
    endtask

    task automatic test_read;
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        int base;
        base = rd_cnt;
        bus_start;
        write_byte(8'hA0, a0); write_byte(8'h10, a1);
        bus_start;
        write_byte(8'hA1, a2);
        read_byte(1'b0, d0); read_byte(1'b1, d1);
        bus_stop;
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
        n_cmp++; if (d0 !== 8'h5A) begin n_err++; $display("FAIL rd_byte0: got %h want 5a", d0); end
        n_cmp++; if (d1 !== (AUTOINC ? 8'hC3 : 8'h5A)) begin n_err++; $display("FAIL rd_byte1: got %h want %h", d1, AUTOINC ? 8'hC3 : 8'h5A); end
        n_cmp++; if (rd_cnt - base !== 2) begin n_err++; $display("FAIL rd_count: got %0d want 2", rd_cnt - base); end
        n_cmp++; if (rd_a[base] !== 8'h10 || rd_a[base+1] !== (AUTOINC ? 8'h11 : 8'h10)) begin n_err++; $display("FAIL rd_addrs: got %h/%h", rd_a[base], rd_a[base+1]); end
        n_cmp++; if (reg_addr !== (AUTOINC ? 8'h11 : 8'h10)) begin n_err++; $display("FAIL rd_ptr_after: got %h", reg_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_off: got %b want 0", busy); end
    endtask

    task automatic test_mismatch;
        logic a0, a1;
        int wb, rb, lb, bb;
        wb = wr_cnt; rb = rd_cnt; lb = low_cnt; bb = busy_cnt;
        bus_start;
        write_byte(8'hA2, a0); write_byte(8'h00, a1);
        bus_stop;
        n_cmp++; if ({a0, a1} !== 2'b11) begin n_err++; $display("FAIL mm_nacks: got %b want 11", {a0, a1}); end
        n_cmp++; if (low_cnt - lb !== 0) begin n_err++; $display("FAIL mm_sda_low: got %0d want 0", low_cnt - lb); end
        n_cmp++; if (wr_cnt - wb !== 0 || rd_cnt - rb !== 0) begin n_err++; $display("FAIL mm_strobes: got %0d/%0d want 0/0", wr_cnt - wb, rd_cnt - rb); end
        n_cmp++; if (busy_cnt - bb !== 0) begin n_err++; $display("FAIL mm_busy: got %0d want 0", busy_cnt - bb); end
    endtask

    task automatic test_abort;
        logic a0, a1, a2, a3, a4;
        int base;
        base = wr_cnt;
        bus_start;
        write_byte(8'hA0, a0); write_byte(8'h07, a1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop;
        n_cmp++; if (wr_cnt - base !== 0) begin n_err++; $display("FAIL ab_no_wr: got %0d want 0", wr_cnt - base); end
        n_cmp++; if (reg_addr !== 8'h07) begin n_err++; $display("FAIL ab_ptr: got %h want 07", reg_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_busy: got %b want 0", busy); end
        bus_start;
        write_byte(8'hA0, a2); write_byte(8'h08, a3); write_byte(8'h55, a4);
        bus_stop;
        n_cmp++; if ({a0, a1, a2, a3, a4} !== 5'b00000) begin n_err++; $display("FAIL ab_acks: got %b want 00000", {a0, a1, a2, a3, a4}); end
        n_cmp++; if (wr_cnt - base !== 1 || wr_a[base] !== 8'h08 || wr_d[base] !== 8'h55) begin n_err++; $display("FAIL ab_next: got %0d %h/%h want 1 08/55", wr_cnt - base, wr_a[base], wr_d[base]); end
    endtask

    task automatic test_wrap;
        logic a0, a1, a2, a3;
        int base;
        base = wr_cnt;
        bus_start;
        write_byte(8'hA0, a0); write_byte(8'hFF, a1); write_byte(8'h11, a2); write_byte(8'h22, a3);
        bus_stop;
        n_cmp++; if ({a0, a1, a2, a3} !== 4'b0000) begin n_err++; $display("FAIL wrap_acks: got %b want 0000", {a0, a1, a2, a3}); end
        n_cmp++; if (wr_cnt - base !== 2) begin n_err++; $display("FAIL wrap_count: got %0d want 2", wr_cnt - base); end
        n_cmp++; if (wr_a[base] !== 8'hFF || wr_d[base] !== 8'h11) begin n_err++; $display("FAIL wrap_0: got %h/%h want ff/11", wr_a[base], wr_d[base]); end
        n_cmp++; if (wr_a[base+1] !== (AUTOINC ? 8'h00 : 8'hFF) || wr_d[base+1] !== 8'h22) begin n_err++; $display("FAIL wrap_1: got %h/%h want %h/22", wr_a[base+1], wr_d[base+1], AUTOINC ? 8'h00 : 8'hFF); end
    endtask

    task automatic test_reset_mid_read;
        logic a0, a1, a2;
        logic [7:0] d;
        bus_start;
        write_byte(8'hA0, a0); write_byte(8'h20, a1);
        bus_start;
        write_byte(8'hA1, a2);
        read_bits(4, d);
        #Q;
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL mr_acks: got %b want 000", {a0, a1, a2}); end
        n_cmp++; if (sda !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL mr_driving: got sda %b busy %b want 0 1", sda, busy); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (sda !== 1'b1) begin n_err++; $display("FAIL mr_sda_rel: got %b want 1", sda); end
        n_cmp++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin n_err++; $display("FAIL mr_regs: got %h/%h want 00/00", reg_addr, reg_wdata); end
        n_cmp++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mr_flags: got %b%b%b want 000", reg_wr, reg_rd, busy); end
        #(2*Q);
        reset_n = 1'b1;
        bus_stop;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'hC3;
        test_reset;
        test_write;
        test_read;
        test_mismatch;
        test_abort;
        test_wrap;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) that answers an external I2C controller on the shared SCL/SDA bus and exposes a simple byte-wide register-access port to on-chip logic. It runs entirely in the `clk` domain, sampling SCL and SDA through synchronisers, and drives SDA open-drain only. Its register protocol is standard: address byte, then a pointer byte, then write data bytes or a read with repeated START. It is the bus-side counterpart to the team's I2C master and is used for config-register access and for master loopback benches.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target responds to.
- `clk`  input  1  system clock; must be ≥ 20× the SCL frequency.
- `reset_n`  input  1  reset; asynchronous, active-low.
- `scl`  input  1  I2C clock from the controller (no clock stretching).
- `sda`  inout  1  I2C data, open-drain: driven 0 or 'z', never driven 1.
- `reg_addr`  output  8  register pointer.
- `reg_wdata`  output  8  last received write byte.
- `reg_wr`  output  1  one-`clk` pulse; `reg_wdata` is valid for `reg_addr`.
- `reg_rd`  output  1  one-`clk` pulse; `reg_rdata` is sampled in the same cycle.
- `reg_rdata`  input  8  read data for `reg_addr`.
- `busy`  output  1  high from an address-matched START until the following STOP.

## Operation
- **Synchronisers:** 2-FF on `scl` and `sda`, plus a third stage for edge detection.
- **START:** synced SDA falls while SCL is high. Goes to ADDR from any state, including mid-byte (repeated START).
- **STOP:** synced SDA rises while SCL is high. Goes to IDLE from any state and clears `busy`. A partial byte is discarded, so there is no `reg_wr`.
- **Bit timing:** bits are sampled on synced SCL rise. SDA output changes only on synced SCL fall.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **ADDR:** shift 8 bits MSB first. On the 8th rise, compare bits [7:1] with `SLAVE_ADDR`.
  - Mismatch: go to IGNORE (SDA released; wait for START or STOP).
  - Match: set `busy`, latch rw = bit0, go to ADDR_ACK.
- **ADDR_ACK:** pull SDA low from the next SCL fall to the following SCL fall.
  - rw=0: go to PTR.
  - rw=1: go to RDATA.
- **PTR:** receive 8 bits. On the 8th rise, `reg_addr` <= byte. ACK as in ADDR_ACK, then go to WDATA.
- **WDATA:** on the 8th rise, `reg_wdata` <= byte and `reg_wr` pulses. ACK every byte, then return to WDATA. The pointer advances after the pulse (see Configuration).
- **RDATA:**
  - On the SCL fall that ends the ACK: pulse `reg_rd`, load the shifter from `reg_rdata`, drive the MSB (release SDA for 1, pull low for 0).
  - Bits 6..0 go out on subsequent falls.
  - After the 8th bit, release SDA on the next fall.
- **RDATA_ACK:** sample the controller's bit on the 9th rise.
  - 0 (ACK): advance the pointer, go to RDATA.
  - 1 (NACK): go to IGNORE.
- **Pointer persistence:** `reg_addr` persists across transactions, so pointer-write + repeated-START + read works.
- **Pointer width:** pointer arithmetic is 8-bit modulo 256 (0xFF wraps to 0x00).

## Timing
- **Reset values:** SDA released ('z'), `reg_addr`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=0, state IDLE.
- **Reset mid-transfer:** SDA is released immediately (asynchronously).
- **Synchroniser latency:** bus edge to internal detection is 2–3 `clk` cycles.
- **Write strobe:** `reg_wr` asserts within 3 `clk` of the 8th SCL rise of a data byte and lasts exactly 1 `clk`.
- **Read fetch:** `reg_rd` and the `reg_rdata` sample happen within 3 `clk` of the ACK-ending SCL fall. `reg_rdata` must be combinationally valid for the current `reg_addr`.
- **SDA drive delay:** SDA drive changes within 3 `clk` of the synced SCL fall. This meets the hold time because `clk` ≥ 20× SCL.
- **Simultaneous events:** START/STOP detection takes priority over bit sampling in the same cycle.

## Configuration
- `I2C_SLAVE_AUTOINC_EN` defined: the pointer increments after each written byte and after each controller-ACKed read byte.
- Undefined: the pointer changes only in PTR. Successive writes and reads all target the same `reg_addr`.

## Test plan
- **Write, two bytes:** START, 0xA0, ptr 0x03, data 0xA5, 0x3C, STOP → ACK on all four bytes; `reg_wr` pulses with (0x03, 0xA5) then (0x04, 0x3C); `busy` falls after STOP. Without AUTOINC, both pulses use 0x03.
- **Random read:** START, 0xA0, ptr 0x10, repeated START, 0xA1, bench `reg_rdata`=0x5A then 0xC3, controller ACK then NACK, STOP → SDA carries 0x5A, 0xC3; `reg_rd` pulses at 0x10, 0x11.
- **Address mismatch:** START, 0xA2, 0x00, STOP → SDA never driven low, no `reg_wr`/`reg_rd`, `busy`=0.
- **Abort mid-byte:** after ptr 0x07, send 4 data bits then STOP → no `reg_wr`, `reg_addr`=0x07, state IDLE; the next transaction works.
- **Pointer wrap:** ptr 0xFF, write 0x11, 0x22 → pulses at 0xFF then 0x00.
- **Reset mid-read:** assert `reset_n` during RDATA bit 3 → SDA released immediately, all outputs at reset values.
